// File: rtl/masked_alu_pkg.sv
// Shared op-codes and FSM states for the masked ALU front-end arbiter.
package masked_alu_pkg;

    typedef enum logic [1:0] {
        OpAdd     = 2'b00,
        OpSub     = 2'b01,
        OpB2a     = 2'b10,
        OpIllegal = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

endpackage

// File: rtl/masked_alu_arbiter_if.sv
// Request/response bus for two requesters plus the link to the shared masked ALU.
// The master modport is the arbiter's view; slave is the requesters' and ALU's view.
interface masked_alu_arbiter_if #(
    parameter int unsigned BIT_WIDTH = 32
);
    logic                 req0_valid, req1_valid;
    logic [1:0]           req0_op, req1_op;
    logic [BIT_WIDTH-1:0] req0_rs1_s0, req0_rs1_s1, req0_rs2_s0, req0_rs2_s1;
    logic [BIT_WIDTH-1:0] req1_rs1_s0, req1_rs1_s1, req1_rs2_s0, req1_rs2_s1;
    logic                 req0_ack, req1_ack, req0_done, req1_done;
    logic [BIT_WIDTH-1:0] req0_rd_s0, req0_rd_s1, req1_rd_s0, req1_rd_s1;

    logic                 alu_valid, alu_op_add, alu_op_sub, alu_op_b2a, alu_flush;
    logic [BIT_WIDTH-1:0] alu_rs1_s0, alu_rs1_s1, alu_rs2_s0, alu_rs2_s1;
    logic                 alu_ready;
    logic [BIT_WIDTH-1:0] alu_rd_s0, alu_rd_s1;

    modport master (
        input  req0_valid, req0_op, req0_rs1_s0, req0_rs1_s1, req0_rs2_s0, req0_rs2_s1,
        input  req1_valid, req1_op, req1_rs1_s0, req1_rs1_s1, req1_rs2_s0, req1_rs2_s1,
        output req0_ack, req1_ack, req0_done, req1_done,
        output req0_rd_s0, req0_rd_s1, req1_rd_s0, req1_rd_s1,
        output alu_valid, alu_op_add, alu_op_sub, alu_op_b2a, alu_flush,
        output alu_rs1_s0, alu_rs1_s1, alu_rs2_s0, alu_rs2_s1,
        input  alu_ready, alu_rd_s0, alu_rd_s1
    );

    modport slave (
        output req0_valid, req0_op, req0_rs1_s0, req0_rs1_s1, req0_rs2_s0, req0_rs2_s1,
        output req1_valid, req1_op, req1_rs1_s0, req1_rs1_s1, req1_rs2_s0, req1_rs2_s1,
        input  req0_ack, req1_ack, req0_done, req1_done,
        input  req0_rd_s0, req0_rd_s1, req1_rd_s0, req1_rd_s1,
        input  alu_valid, alu_op_add, alu_op_sub, alu_op_b2a, alu_flush,
        input  alu_rs1_s0, alu_rs1_s1, alu_rs2_s0, alu_rs2_s1,
        output alu_ready, alu_rd_s0, alu_rd_s1
    );
endinterface

// File: rtl/masked_alu_rr_arb.sv
// Two-way round-robin grant; the last-grant pointer only moves on an accepted grant.
module masked_alu_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_valid,
    output logic       gnt_id
);
    logic last_q;

    // Contention goes to the requester not granted last; a lone requester always wins.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = req[1];
        if (req == 2'b11) begin
            gnt_id = ~last_q;
        end
    end

    // Last-grant pointer; reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= gnt_id;
        end
    end
endmodule

// File: rtl/masked_alu_arbiter.sv
// Arbitrates two requesters onto one shared masked ALU. Shares pass through untouched.
module masked_alu_arbiter #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic g_clk,
    input  logic g_reset,
    input  logic flush,
    output logic err_timeout,
    masked_alu_arbiter_if.master bus
);
    import masked_alu_pkg::*;

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    op_e                  op_q, win_op;
    logic                 gid_q, gnt_id, gnt_valid, accept, timeout_hit, issue;
    logic [CNT_W-1:0]     cnt_q;
    logic                 err_q, alu_flush_q;
    logic [BIT_WIDTH-1:0] rs1_s0_q, rs1_s1_q, rs2_s0_q, rs2_s1_q;
    logic [BIT_WIDTH-1:0] win_rs1_s0, win_rs1_s1, win_rs2_s0, win_rs2_s1;
    logic [BIT_WIDTH-1:0] rd_s0_q [2];
    logic [BIT_WIDTH-1:0] rd_s1_q [2];

    masked_alu_rr_arb u_arb (
        .clk       (g_clk),
        .reset     (g_reset),
        .req       ({bus.req1_valid, bus.req0_valid}),
        .advance   (accept),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign issue       = (state_q == StIssue);
    assign accept      = !g_reset && !flush && (state_q == StIdle) && gnt_valid;
    // Fires in the TIMEOUT-th ISSUE cycle; a late alu_ready in that cycle still wins.
    assign timeout_hit = issue && !flush && !bus.alu_ready && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Select the winning requester's op and operand shares.
    always_comb begin
        win_op     = op_e'(bus.req0_op);
        win_rs1_s0 = bus.req0_rs1_s0;
        win_rs1_s1 = bus.req0_rs1_s1;
        win_rs2_s0 = bus.req0_rs2_s0;
        win_rs2_s1 = bus.req0_rs2_s1;
        if (gnt_id) begin
            win_op     = op_e'(bus.req1_op);
            win_rs1_s0 = bus.req1_rs1_s0;
            win_rs1_s1 = bus.req1_rs1_s1;
            win_rs2_s0 = bus.req1_rs2_s0;
            win_rs2_s1 = bus.req1_rs2_s1;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = (win_op == OpIllegal) ? StResp : StIssue;
            StIssue: begin
                if (bus.alu_ready)    state_d = StResp;
                else if (timeout_hit) state_d = StIdle;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    // State register.
    always_ff @(posedge g_clk) begin
        if (g_reset) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Operand capture, result capture, watchdog and sticky error.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            gid_q       <= 1'b0;
            op_q        <= OpAdd;
            rs1_s0_q    <= '0;
            rs1_s1_q    <= '0;
            rs2_s0_q    <= '0;
            rs2_s1_q    <= '0;
            rd_s0_q[0]  <= '0;
            rd_s1_q[0]  <= '0;
            rd_s0_q[1]  <= '0;
            rd_s1_q[1]  <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            alu_flush_q <= 1'b0;
        end else begin
            alu_flush_q <= flush || timeout_hit;
            if (timeout_hit) err_q <= 1'b1;
            if (accept) begin
                gid_q    <= gnt_id;
                op_q     <= win_op;
                rs1_s0_q <= win_rs1_s0;
                rs1_s1_q <= win_rs1_s1;
                rs2_s0_q <= win_rs2_s0;
                rs2_s1_q <= win_rs2_s1;
                cnt_q    <= '0;
                // Illegal ops bypass the ALU and return zero shares.
                if (win_op == OpIllegal) begin
                    rd_s0_q[gnt_id] <= '0;
                    rd_s1_q[gnt_id] <= '0;
                end
            end
            if (issue && !flush) begin
                if (bus.alu_ready) begin
                    rd_s0_q[gid_q] <= bus.alu_rd_s0;
                    rd_s1_q[gid_q] <= bus.alu_rd_s1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.req0_ack   = accept && !gnt_id;
    assign bus.req1_ack   = accept && gnt_id;
    assign bus.req0_done  = (state_q == StResp) && !flush && !gid_q;
    assign bus.req1_done  = (state_q == StResp) && !flush && gid_q;
    assign bus.req0_rd_s0 = rd_s0_q[0];
    assign bus.req0_rd_s1 = rd_s1_q[0];
    assign bus.req1_rd_s0 = rd_s0_q[1];
    assign bus.req1_rd_s1 = rd_s1_q[1];

    assign bus.alu_valid  = issue;
    assign bus.alu_op_add = issue && (op_q == OpAdd);
    assign bus.alu_op_sub = issue && (op_q == OpSub);
    assign bus.alu_op_b2a = issue && (op_q == OpB2a);
    assign bus.alu_flush  = alu_flush_q;
    assign bus.alu_rs1_s0 = rs1_s0_q;
    assign bus.alu_rs1_s1 = rs1_s1_q;
    assign bus.alu_rs2_s0 = rs2_s0_q;
    assign bus.alu_rs2_s1 = rs2_s1_q;
    assign err_timeout    = err_q;
endmodule

// File: tb/tb_masked_alu_arbiter.sv
// Directed bench for masked_alu_arbiter: inputs change on the falling edge, outputs are
// compared 1 time unit later.
module tb_masked_alu_arbiter;
    localparam int unsigned W = 32;

    logic g_clk = 1'b0;
    logic g_reset, flush, err_timeout;
    int   n_checks, n_pass;
    logic exp_gid;

    masked_alu_arbiter_if #(.BIT_WIDTH(W)) bus ();

    masked_alu_arbiter #(
        .BIT_WIDTH (W),
        .TIMEOUT   (8)
    ) dut (
        .g_clk       (g_clk),
        .g_reset     (g_reset),
        .flush       (flush),
        .err_timeout (err_timeout),
        .bus         (bus)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        g_reset  = 1'b1;
        flush    = 1'b0;
        bus.req0_valid = 1'b1;  // held through reset: must not be acked
        bus.req1_valid = 1'b0;
        bus.req0_op = 2'b00;
        bus.req1_op = 2'b00;
        bus.req0_rs1_s0 = '0; bus.req0_rs1_s1 = '0; bus.req0_rs2_s0 = '0; bus.req0_rs2_s1 = '0;
        bus.req1_rs1_s0 = '0; bus.req1_rs1_s1 = '0; bus.req1_rs2_s0 = '0; bus.req1_rs2_s1 = '0;
        bus.alu_ready = 1'b0;
        bus.alu_rd_s0 = '0;
        bus.alu_rd_s1 = '0;

        // Reset state
        repeat (2) @(negedge g_clk);
        #1;
        chk_bit("rst_ack0", bus.req0_ack, 1'b0);
        chk_bit("rst_alu_valid", bus.alu_valid, 1'b0);
        chk_bit("rst_alu_flush", bus.alu_flush, 1'b0);
        chk_bit("rst_err", err_timeout, 1'b0);
        chk_bit("rst_done0", bus.req0_done, 1'b0);
        chk_word("rst_rd0", bus.req0_rd_s0, 32'd0);
        chk_word("rst_alu_rs1", bus.alu_rs1_s0, 32'd0);

        // Single add from req0, ALU ready in the third ISSUE cycle
        @(negedge g_clk);
        g_reset = 1'b0;
        bus.req0_rs1_s0 = 32'd5; bus.req0_rs2_s0 = 32'd3;
        #1;
        chk_bit("t0_ack0", bus.req0_ack, 1'b1);
        chk_bit("t0_ack1", bus.req1_ack, 1'b0);
        @(negedge g_clk);
        bus.req0_valid = 1'b0;
        #1;
        chk_bit("t1_alu_valid", bus.alu_valid, 1'b1);
        chk_bit("t1_op_add", bus.alu_op_add, 1'b1);
        chk_bit("t1_op_sub", bus.alu_op_sub, 1'b0);
        chk_word("t1_rs1_s0", bus.alu_rs1_s0, 32'd5);
        chk_word("t1_rs2_s0", bus.alu_rs2_s0, 32'd3);
        @(negedge g_clk);
        #1;
        chk_bit("t2_alu_valid", bus.alu_valid, 1'b1);
        chk_word("t2_rs2_stable", bus.alu_rs2_s0, 32'd3);
        @(negedge g_clk);
        bus.alu_ready = 1'b1; bus.alu_rd_s0 = 32'd8; bus.alu_rd_s1 = 32'h1234;
        #1;
        chk_bit("t3_no_done", bus.req0_done, 1'b0);
        @(negedge g_clk);
        bus.alu_ready = 1'b0;
        #1;
        chk_bit("t4_done0", bus.req0_done, 1'b1);
        chk_bit("t4_done1", bus.req1_done, 1'b0);
        chk_bit("t4_alu_valid", bus.alu_valid, 1'b0);
        chk_word("t4_rd0_s0", bus.req0_rd_s0, 32'd8);
        chk_word("t4_rd0_s1", bus.req0_rd_s1, 32'h1234);
        // Stray alu_ready in IDLE must not touch the results
        @(negedge g_clk);
        bus.alu_ready = 1'b1; bus.alu_rd_s0 = 32'hffff;
        #1;
        chk_bit("t5_done0_low", bus.req0_done, 1'b0);
        @(negedge g_clk);
        bus.alu_ready = 1'b0;
        #1;
        chk_word("stray_ready_rd0", bus.req0_rd_s0, 32'd8);

        // Round-robin from reset: both requesters valid back to back
        @(negedge g_clk);
        g_reset = 1'b1;
        @(negedge g_clk);
        g_reset = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_rs1_s0 = 32'd10;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b01; bus.req1_rs1_s0 = 32'd20;
        for (int i = 0; i < 4; i++) begin
            exp_gid = (i % 2 == 1);
            #1;
            chk_bit("rr_ack0", bus.req0_ack, !exp_gid);
            chk_bit("rr_ack1", bus.req1_ack, exp_gid);
            @(negedge g_clk);
            bus.alu_ready = 1'b1; bus.alu_rd_s0 = 100 + i; bus.alu_rd_s1 = 200 + i;
            #1;
            chk_bit("rr_alu_valid", bus.alu_valid, 1'b1);
            chk_bit("rr_op_sub", bus.alu_op_sub, exp_gid);
            chk_word("rr_rs1", bus.alu_rs1_s0, exp_gid ? 32'd20 : 32'd10);
            @(negedge g_clk);
            bus.alu_ready = 1'b0;
            #1;
            chk_bit("rr_done0", bus.req0_done, !exp_gid);
            chk_bit("rr_done1", bus.req1_done, exp_gid);
            chk_bit("rr_resp_no_ack", bus.req0_ack | bus.req1_ack, 1'b0);
            chk_word("rr_rd", exp_gid ? bus.req1_rd_s1 : bus.req0_rd_s1, 200 + i);
            @(negedge g_clk);
        end

        // Flush in IDLE suppresses the ack
        bus.req1_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk_bit("flush_idle_ack0", bus.req0_ack, 1'b0);
        @(negedge g_clk);
        flush = 1'b0;
        #1;
        chk_bit("flush_idle_pulse", bus.alu_flush, 1'b1);
        chk_bit("fl_ack0", bus.req0_ack, 1'b1);
        @(negedge g_clk);
        bus.req0_valid = 1'b0;
        #1;
        chk_bit("fl_issue1", bus.alu_valid, 1'b1);
        chk_bit("fl_no_pulse", bus.alu_flush, 1'b0);
        // Flush in the second ISSUE cycle
        @(negedge g_clk);
        flush = 1'b1;
        #1;
        chk_bit("fl_issue2", bus.alu_valid, 1'b1);
        @(negedge g_clk);
        flush = 1'b0;
        #1;
        chk_bit("fl_pulse", bus.alu_flush, 1'b1);
        chk_bit("fl_idle", bus.alu_valid, 1'b0);
        chk_bit("fl_no_done", bus.req0_done, 1'b0);
        @(negedge g_clk);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        chk_bit("fl_pulse_once", bus.alu_flush, 1'b0);
        chk_bit("fl_no_done2", bus.req0_done, 1'b0);
        chk_bit("fl_rr_ack1", bus.req1_ack, 1'b1);
        chk_bit("fl_rr_ack0", bus.req0_ack, 1'b0);
        @(negedge g_clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.alu_ready = 1'b1; bus.alu_rd_s0 = 32'd55; bus.alu_rd_s1 = 32'd66;
        #1;
        chk_bit("fl_next_sub", bus.alu_op_sub, 1'b1);
        @(negedge g_clk);
        bus.alu_ready = 1'b0;
        #1;
        chk_bit("fl_next_done1", bus.req1_done, 1'b1);
        chk_word("fl_next_rd1", bus.req1_rd_s0, 32'd55);

        // Illegal op from req1
        @(negedge g_clk);
        bus.req1_valid = 1'b1; bus.req1_op = 2'b11;
        #1;
        chk_bit("ill_ack1", bus.req1_ack, 1'b1);
        @(negedge g_clk);
        bus.req1_valid = 1'b0;
        #1;
        chk_bit("ill_alu_valid", bus.alu_valid, 1'b0);
        chk_bit("ill_done1", bus.req1_done, 1'b1);
        chk_word("ill_rd1_s0", bus.req1_rd_s0, 32'd0);
        chk_word("ill_rd1_s1", bus.req1_rd_s1, 32'd0);
        chk_word("ill_rd0_held", bus.req0_rd_s0, 32'd102);
        @(negedge g_clk);
        #1;
        chk_bit("ill_done_once", bus.req1_done, 1'b0);

        // Watchdog: ALU never ready, TIMEOUT = 8
        @(negedge g_clk);
        bus.req0_valid = 1'b1;
        #1;
        chk_bit("wd_ack0", bus.req0_ack, 1'b1);
        @(negedge g_clk);
        bus.req0_valid = 1'b0;
        repeat (7) @(negedge g_clk);
        #1;
        chk_bit("wd_issue8", bus.alu_valid, 1'b1);
        chk_bit("wd_err_before", err_timeout, 1'b0);
        @(negedge g_clk);
        #1;
        chk_bit("wd_err", err_timeout, 1'b1);
        chk_bit("wd_flush", bus.alu_flush, 1'b1);
        chk_bit("wd_idle", bus.alu_valid, 1'b0);
        chk_bit("wd_no_done", bus.req0_done, 1'b0);
        @(negedge g_clk);
        #1;
        chk_bit("wd_flush_once", bus.alu_flush, 1'b0);
        chk_bit("wd_err_sticky", err_timeout, 1'b1);
        chk_bit("wd_no_done2", bus.req0_done, 1'b0);

        // Reset mid-ISSUE, last grant was requester 0
        @(negedge g_clk);
        bus.req0_valid = 1'b1;
        #1;
        chk_bit("rm_ack0", bus.req0_ack, 1'b1);
        @(negedge g_clk);
        bus.req0_valid = 1'b0;
        #1;
        chk_bit("rm_issue", bus.alu_valid, 1'b1);
        g_reset = 1'b1;
        @(negedge g_clk);
        #1;
        chk_bit("rm_alu_valid", bus.alu_valid, 1'b0);
        chk_bit("rm_alu_flush", bus.alu_flush, 1'b0);
        chk_bit("rm_err", err_timeout, 1'b0);
        chk_bit("rm_done0", bus.req0_done, 1'b0);
        chk_word("rm_alu_rs1", bus.alu_rs1_s0, 32'd0);
        chk_word("rm_rd0", bus.req0_rd_s0, 32'd0);
        g_reset = 1'b0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        chk_bit("rm_first_ack0", bus.req0_ack, 1'b1);
        chk_bit("rm_first_ack1", bus.req1_ack, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
